// File: rtl/gpc_4t_ifetch.sv
`default_nettype none
// ============================================================================
// Module      : gpc_4t_ifetch
// Description : Four-thread round-robin instruction fetch requester with a
//               2-entry return FIFO and a muxed program-load write path.
// Revision    : 1.0 - initial release
// ============================================================================
module gpc_4t_ifetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          NUM_THREADS = 4
) (
    input  logic                           clock,
    input  logic                           rst,
    input  logic [NUM_THREADS-1:0]         thread_en,
    input  logic                           redirect_valid,
    input  logic [$clog2(NUM_THREADS)-1:0] redirect_thread,
    input  logic [31:0]                    redirect_pc,
    input  logic                           ld_valid,
    input  logic [31:0]                    ld_address,
    input  logic [31:0]                    ld_data,
    output logic                           ld_ready,
    output logic [31:0]                    mem_address,
    output logic [31:0]                    mem_data,
    output logic                           mem_rden,
    output logic                           mem_wren,
    input  logic [31:0]                    mem_q,
    output logic                           fetch_valid,
    input  logic                           fetch_ready,
    output logic [$clog2(NUM_THREADS)-1:0] fetch_thread,
    output logic [31:0]                    fetch_pc,
    output logic [31:0]                    fetch_instr
);

    localparam int c_TID_W = $clog2(NUM_THREADS);

    logic [31:0]        r_pc [NUM_THREADS];
    logic [c_TID_W-1:0] r_rr;
    logic               r_inflight;
    logic [c_TID_W-1:0] r_tag_thread;
    logic [31:0]        r_tag_pc;

    // Return FIFO; slot 0 is always the head, entries are kept compacted.
    logic [1:0]         r_v;
    logic [c_TID_W-1:0] r_th  [2];
    logic [31:0]        r_fpc [2];
    logic [31:0]        r_ins [2];

    logic [NUM_THREADS-1:0] w_elig;
    logic                   w_found;
    logic [c_TID_W-1:0]     w_sel;
    logic [c_TID_W-1:0]     w_cand;
    logic                   w_load;
    logic [1:0]             w_occ;
    logic                   w_room;
    logic                   w_issue;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_keep0;
    logic                   w_keep1;
    logic [1:0]             w_nv;
    logic [c_TID_W-1:0]     w_nth  [2];
    logic [31:0]            w_npc  [2];
    logic [31:0]            w_nins [2];

    // A thread being redirected this cycle may not issue from its stale PC.
    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            w_elig[t] = thread_en[t] && !(redirect_valid && (redirect_thread == c_TID_W'(t)));
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int i = 1; i <= NUM_THREADS; i++) begin
            w_cand = r_rr + c_TID_W'(i);
            if (!w_found && w_elig[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    assign w_load  = ld_valid && !rst;
    assign w_occ   = {1'b0, r_v[0]} + {1'b0, r_v[1]} + {1'b0, r_inflight};
    assign w_room  = (w_occ < 2'd2);
    assign w_issue = !rst && !ld_valid && w_room && w_found;

    assign ld_ready    = w_load;
    assign mem_wren    = w_load;
    assign mem_rden    = w_issue;
    assign mem_address = w_load ? ld_address : (w_issue ? r_pc[w_sel] : 32'h0);
    assign mem_data    = w_load ? ld_data : 32'h0;

    assign fetch_valid  = r_v[0];
    assign fetch_thread = r_th[0];
    assign fetch_pc     = r_fpc[0];
    assign fetch_instr  = r_ins[0];

    assign w_push  = r_inflight && !(redirect_valid && (redirect_thread == r_tag_thread));
    assign w_pop   = r_v[0] && fetch_ready;
    assign w_keep0 = r_v[0] && !w_pop && !(redirect_valid && (redirect_thread == r_th[0]));
    assign w_keep1 = r_v[1] && !(redirect_valid && (redirect_thread == r_th[1]));

    // Survivors move toward the head in order; the returning word lands behind them.
    always_comb begin
        w_nv      = 2'b00;
        w_nth[0]  = '0;
        w_nth[1]  = '0;
        w_npc[0]  = 32'h0;
        w_npc[1]  = 32'h0;
        w_nins[0] = 32'h0;
        w_nins[1] = 32'h0;
        if (w_keep0) begin
            w_nv[0] = 1'b1; w_nth[0] = r_th[0]; w_npc[0] = r_fpc[0]; w_nins[0] = r_ins[0];
        end else if (w_keep1) begin
            w_nv[0] = 1'b1; w_nth[0] = r_th[1]; w_npc[0] = r_fpc[1]; w_nins[0] = r_ins[1];
        end else if (w_push) begin
            w_nv[0] = 1'b1; w_nth[0] = r_tag_thread; w_npc[0] = r_tag_pc; w_nins[0] = mem_q;
        end
        if (w_keep0 && w_keep1) begin
            w_nv[1] = 1'b1; w_nth[1] = r_th[1]; w_npc[1] = r_fpc[1]; w_nins[1] = r_ins[1];
        end else if ((w_keep0 ^ w_keep1) && w_push) begin
            w_nv[1] = 1'b1; w_nth[1] = r_tag_thread; w_npc[1] = r_tag_pc; w_nins[1] = mem_q;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                r_pc[t] <= RESET_PC;
            end
            r_rr         <= c_TID_W'(NUM_THREADS - 1);
            r_inflight   <= 1'b0;
            r_tag_thread <= '0;
            r_tag_pc     <= 32'h0;
            r_v          <= 2'b00;
            for (int e = 0; e < 2; e++) begin
                r_th[e]  <= '0;
                r_fpc[e] <= 32'h0;
                r_ins[e] <= 32'h0;
            end
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (redirect_valid && (redirect_thread == c_TID_W'(t))) begin
                    r_pc[t] <= redirect_pc;
                end else if (w_issue && (w_sel == c_TID_W'(t))) begin
                    r_pc[t] <= r_pc[t] + 32'd4;
                end
            end
            r_inflight <= w_issue;
            if (w_issue) begin
                r_rr         <= w_sel;
                r_tag_thread <= w_sel;
                r_tag_pc     <= r_pc[w_sel];
            end
            r_v <= w_nv;
            for (int e = 0; e < 2; e++) begin
                r_th[e]  <= w_nth[e];
                r_fpc[e] <= w_npc[e];
                r_ins[e] <= w_nins[e];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gpc_4t_ifetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpc_4t_ifetch
// Description : Directed self-checking bench for gpc_4t_ifetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpc_4t_ifetch;

    logic        clock = 1'b0;
    logic        rst;
    logic [3:0]  thread_en;
    logic        redirect_valid;
    logic [1:0]  redirect_thread;
    logic [31:0] redirect_pc;
    logic        ld_valid;
    logic [31:0] ld_address;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_rden;
    logic        mem_wren;
    logic [31:0] mem_q = 32'h0;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [1:0]  fetch_thread;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] iss_q [$];
    logic [65:0] fq    [$];

    gpc_4t_ifetch #(
        .RESET_PC    (32'h0000_0000),
        .NUM_THREADS (4)
    ) dut (
        .clock           (clock),
        .rst             (rst),
        .thread_en       (thread_en),
        .redirect_valid  (redirect_valid),
        .redirect_thread (redirect_thread),
        .redirect_pc     (redirect_pc),
        .ld_valid        (ld_valid),
        .ld_address      (ld_address),
        .ld_data         (ld_data),
        .ld_ready        (ld_ready),
        .mem_address     (mem_address),
        .mem_data        (mem_data),
        .mem_rden        (mem_rden),
        .mem_wren        (mem_wren),
        .mem_q           (mem_q),
        .fetch_valid     (fetch_valid),
        .fetch_ready     (fetch_ready),
        .fetch_thread    (fetch_thread),
        .fetch_pc        (fetch_pc),
        .fetch_instr     (fetch_instr)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {2'b00, a[31:2]} ^ 32'hC0DE_0000;
    endfunction

    always @(posedge clock) mem_q <= mem_rden ? memf(mem_address) : 32'h0;

    // Record issued addresses and accepted fetches away from the active edge.
    always @(negedge clock) begin
        if (!rst) begin
            if (mem_rden) iss_q.push_back(mem_address);
            if (fetch_valid && fetch_ready) fq.push_back({fetch_thread, fetch_pc, fetch_instr});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; thread_en = 4'h0; redirect_valid = 1'b0; redirect_thread = 2'd0;
        redirect_pc = 32'h0; ld_valid = 1'b0; ld_address = 32'h0; ld_data = 32'h0; fetch_ready = 1'b0;
        tick(2);
        rst = 1'b0;
        iss_q.delete();
        fq.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        rst = 1'b1; thread_en = 4'hF; ld_valid = 1'b1; ld_address = 32'h40; ld_data = 32'h1234;
        tick(2);
        n_chk++; if (fetch_valid !== 1'b0) $display("FAIL reset_fetch_valid: got %b want 0", fetch_valid); else n_pass++;
        n_chk++; if (mem_rden !== 1'b0) $display("FAIL reset_mem_rden: got %b want 0", mem_rden); else n_pass++;
        n_chk++; if (mem_wren !== 1'b0) $display("FAIL reset_mem_wren: got %b want 0", mem_wren); else n_pass++;
        n_chk++; if (ld_ready !== 1'b0) $display("FAIL reset_ld_ready: got %b want 0", ld_ready); else n_pass++;
        n_chk++; if (mem_address !== 32'h0) $display("FAIL reset_mem_address: got %h want 0", mem_address); else n_pass++;
        n_chk++; if (mem_data !== 32'h0) $display("FAIL reset_mem_data: got %h want 0", mem_data); else n_pass++;
        n_chk++; if ({fetch_thread, fetch_pc, fetch_instr} !== 66'h0) $display("FAIL reset_fetch_fields: got %h/%h/%h want 0", fetch_thread, fetch_pc, fetch_instr); else n_pass++;
        rst = 1'b0; ld_valid = 1'b0;
        #1;
        n_chk++; if (mem_rden !== 1'b1 || mem_address !== 32'h0) $display("FAIL reset_first_issue: got rden %b addr %h want 1 0", mem_rden, mem_address); else n_pass++;
        thread_en = 4'h0;
    endtask

    task automatic test_round_robin();
        apply_reset();
        thread_en = 4'hF; fetch_ready = 1'b1;
        tick(40);
        thread_en = 4'h0;
        tick(6);
        n_chk++; if (iss_q.size() < 16) $display("FAIL rr_issue_count: got %0d want >=16", iss_q.size()); else n_pass++;
        for (int k = 0; k < iss_q.size(); k++) begin
            n_chk++; if (iss_q[k] !== 32'(4 * (k / 4))) $display("FAIL rr_issue_addr[%0d]: got %h want %h", k, iss_q[k], 32'(4 * (k / 4))); else n_pass++;
        end
        n_chk++; if (fq.size() != iss_q.size()) $display("FAIL rr_fetch_count: got %0d want %0d", fq.size(), iss_q.size()); else n_pass++;
        for (int k = 0; k < fq.size(); k++) begin
            n_chk++;
            if (fq[k] !== {2'(k % 4), 32'(4 * (k / 4)), memf(32'(4 * (k / 4)))})
                $display("FAIL rr_fetch[%0d]: got t%0d pc %h ins %h want t%0d pc %h", k, fq[k][65:64], fq[k][63:32], fq[k][31:0], k % 4, 4 * (k / 4));
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        thread_en = 4'hF; fetch_ready = 1'b0;
        tick(8);
        n_chk++; if (iss_q.size() != 2) $display("FAIL bp_issue_count: got %0d want 2", iss_q.size()); else n_pass++;
        n_chk++; if (mem_rden !== 1'b0) $display("FAIL bp_rden_stalled: got %b want 0", mem_rden); else n_pass++;
        n_chk++;
        if (fetch_valid !== 1'b1 || fetch_thread !== 2'd0 || fetch_pc !== 32'h0 || fetch_instr !== memf(32'h0))
            $display("FAIL bp_head: got v%b t%0d pc %h ins %h want v1 t0 pc 0", fetch_valid, fetch_thread, fetch_pc, fetch_instr);
        else n_pass++;
        fetch_ready = 1'b1;
        tick(30);
        thread_en = 4'h0;
        tick(6);
        n_chk++; if (iss_q.size() < 10 || fq.size() != iss_q.size()) $display("FAIL bp_resume_count: got issues %0d fetches %0d want equal >=10", iss_q.size(), fq.size()); else n_pass++;
        for (int k = 0; k < fq.size(); k++) begin
            n_chk++;
            if (fq[k][65:32] !== {2'(k % 4), 32'(4 * (k / 4))})
                $display("FAIL bp_fetch[%0d]: got t%0d pc %h want t%0d pc %h", k, fq[k][65:64], fq[k][63:32], k % 4, 4 * (k / 4));
            else n_pass++;
        end
    endtask

    task automatic test_load();
        apply_reset();
        thread_en = 4'hF; fetch_ready = 1'b1;
        tick(7);
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_address = 32'(4 * i); ld_data = 32'hA000_0000 + 32'(i);
            #1;
            n_chk++;
            if (mem_wren !== 1'b1 || mem_rden !== 1'b0 || ld_ready !== 1'b1 || mem_address !== 32'(4 * i) || mem_data !== 32'hA000_0000 + 32'(i))
                $display("FAIL load_cycle[%0d]: got wren %b rden %b rdy %b addr %h data %h want 1 0 1 %h %h", i, mem_wren, mem_rden, ld_ready, mem_address, mem_data, 4 * i, 32'hA000_0000 + 32'(i));
            else n_pass++;
            tick(1);
        end
        ld_valid = 1'b0;
        #1;
        n_chk++; if (ld_ready !== 1'b0 || mem_wren !== 1'b0) $display("FAIL load_release: got rdy %b wren %b want 0 0", ld_ready, mem_wren); else n_pass++;
        tick(20);
        thread_en = 4'h0;
        tick(6);
        n_chk++; if (iss_q.size() < 10 || fq.size() != iss_q.size()) $display("FAIL load_resume_count: got issues %0d fetches %0d", iss_q.size(), fq.size()); else n_pass++;
        for (int k = 0; k < fq.size(); k++) begin
            n_chk++;
            if (fq[k][65:32] !== {2'(k % 4), 32'(4 * (k / 4))} || iss_q[k] !== 32'(4 * (k / 4)))
                $display("FAIL load_seq[%0d]: got t%0d pc %h issue %h want t%0d pc %h", k, fq[k][65:64], fq[k][63:32], iss_q[k], k % 4, 4 * (k / 4));
            else n_pass++;
        end
    endtask

    task automatic test_redirect();
        logic [31:0] m_pc [4];
        int          th;
        // t1 has one entry buffered and one read in flight when redirected.
        apply_reset();
        thread_en = 4'b0010; fetch_ready = 1'b0;
        tick(2);
        n_chk++; if (fetch_valid !== 1'b1 || fetch_thread !== 2'd1 || fetch_pc !== 32'h0) $display("FAIL redir_pre_head: got v%b t%0d pc %h want v1 t1 pc 0", fetch_valid, fetch_thread, fetch_pc); else n_pass++;
        redirect_valid = 1'b1; redirect_thread = 2'd1; redirect_pc = 32'h100; thread_en = 4'hF;
        #1;
        n_chk++; if (mem_rden !== 1'b0) $display("FAIL redir_no_issue: got %b want 0", mem_rden); else n_pass++;
        tick(1);
        redirect_valid = 1'b0;
        n_chk++; if (fetch_valid !== 1'b0) $display("FAIL redir_flushed: got %b want 0", fetch_valid); else n_pass++;
        iss_q.delete(); fq.delete();
        fetch_ready = 1'b1;
        tick(25);
        thread_en = 4'h0;
        tick(6);
        m_pc[0] = 32'h0; m_pc[1] = 32'h100; m_pc[2] = 32'h0; m_pc[3] = 32'h0;
        n_chk++; if (fq.size() < 8 || fq.size() != iss_q.size()) $display("FAIL redir_count: got issues %0d fetches %0d", iss_q.size(), fq.size()); else n_pass++;
        for (int k = 0; k < fq.size(); k++) begin
            th = (2 + k) % 4;
            n_chk++;
            if (fq[k] !== {2'(th), m_pc[th], memf(m_pc[th])})
                $display("FAIL redir_seq[%0d]: got t%0d pc %h want t%0d pc %h", k, fq[k][65:64], fq[k][63:32], th, m_pc[th]);
            else n_pass++;
            m_pc[th] = m_pc[th] + 32'd4;
        end
        // Killing the head while decode accepts it leaves the other thread's entry.
        apply_reset();
        thread_en = 4'hF; fetch_ready = 1'b0;
        tick(3);
        redirect_valid = 1'b1; redirect_thread = 2'd0; redirect_pc = 32'h200; fetch_ready = 1'b1;
        tick(1);
        redirect_valid = 1'b0; fetch_ready = 1'b0;
        n_chk++;
        if (fetch_valid !== 1'b1 || fetch_thread !== 2'd1 || fetch_pc !== 32'h0)
            $display("FAIL redir_compact: got v%b t%0d pc %h want v1 t1 pc 0", fetch_valid, fetch_thread, fetch_pc);
        else n_pass++;
    endtask

    task automatic test_single_thread_wrap();
        apply_reset();
        thread_en = 4'b0100; fetch_ready = 1'b1;
        tick(15);
        thread_en = 4'h0;
        tick(6);
        n_chk++; if (iss_q.size() < 6 || fq.size() != iss_q.size()) $display("FAIL t2_count: got issues %0d fetches %0d", iss_q.size(), fq.size()); else n_pass++;
        for (int k = 0; k < fq.size(); k++) begin
            n_chk++;
            if (fq[k][65:32] !== {2'd2, 32'(4 * k)} || iss_q[k] !== 32'(4 * k))
                $display("FAIL t2_seq[%0d]: got t%0d pc %h issue %h want t2 pc %h", k, fq[k][65:64], fq[k][63:32], iss_q[k], 4 * k);
            else n_pass++;
        end
        redirect_valid = 1'b1; redirect_thread = 2'd2; redirect_pc = 32'hFFFF_FFF8;
        tick(1);
        redirect_valid = 1'b0;
        iss_q.delete(); fq.delete();
        thread_en = 4'b0100;
        tick(8);
        thread_en = 4'h0;
        tick(6);
        n_chk++; if (fq.size() < 4 || fq.size() != iss_q.size()) $display("FAIL wrap_count: got issues %0d fetches %0d", iss_q.size(), fq.size()); else n_pass++;
        for (int k = 0; k < fq.size(); k++) begin
            n_chk++;
            if (fq[k][63:32] !== 32'hFFFF_FFF8 + 32'(4 * k) || iss_q[k] !== 32'hFFFF_FFF8 + 32'(4 * k))
                $display("FAIL wrap_seq[%0d]: got pc %h issue %h want %h", k, fq[k][63:32], iss_q[k], 32'hFFFF_FFF8 + 32'(4 * k));
            else n_pass++;
        end
        redirect_valid = 1'b1; redirect_thread = 2'd2; redirect_pc = 32'h0000_0013;
        tick(1);
        redirect_valid = 1'b0; thread_en = 4'b0100;
        #1;
        n_chk++; if (mem_rden !== 1'b1 || mem_address !== 32'h13) $display("FAIL unaligned_pc: got rden %b addr %h want 1 13", mem_rden, mem_address); else n_pass++;
        thread_en = 4'h0;
    endtask

    task automatic test_reset_midop();
        apply_reset();
        thread_en = 4'hF; fetch_ready = 1'b0;
        tick(2);
        n_chk++; if (fetch_valid !== 1'b1) $display("FAIL midrst_pre: got %b want 1", fetch_valid); else n_pass++;
        rst = 1'b1;
        tick(1);
        n_chk++; if (fetch_valid !== 1'b0 || mem_rden !== 1'b0) $display("FAIL midrst_cleared: got v%b rden %b want 0 0", fetch_valid, mem_rden); else n_pass++;
        rst = 1'b0; fetch_ready = 1'b1;
        iss_q.delete(); fq.delete();
        #1;
        n_chk++; if (mem_rden !== 1'b1 || mem_address !== 32'h0) $display("FAIL midrst_first_issue: got rden %b addr %h want 1 0", mem_rden, mem_address); else n_pass++;
        tick(4);
        thread_en = 4'h0;
        tick(6);
        n_chk++;
        if (fq.size() < 2 || fq[0] !== {2'd0, 32'h0, memf(32'h0)} || fq[1][65:32] !== {2'd1, 32'h0})
            $display("FAIL midrst_after: got n%0d first t%0d pc %h want t0 pc 0 then t1 pc 0", fq.size(), fq[0][65:64], fq[0][63:32]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_load();
        test_redirect();
        test_single_thread_wrap();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
